// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding, default operand width and small
// op-decoding helpers.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  // True for the two divide encodings.
  function automatic logic md_is_div(input md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  // True for the two signed (two's complement) encodings.
  function automatic logic md_is_signed(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration on the {acc, q} pair.
// Multiply: LSB-first shift-add; after WIDTH steps {acc, q} is the product.
// Divide: restoring subtract-shift; after WIDTH steps q is the quotient and
// acc the remainder (acc is always < m, so WIDTH+1 bits are enough).
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Single shift-add or restoring subtract step.
  always_comb begin
    sum   = {1'b0, acc_i} + {1'b0, (q_i[0] ? m_i : {WIDTH{1'b0}})};
    rem   = {acc_i, q_i[WIDTH-1]};
    diff  = rem - {1'b0, m_i};
    acc_o = {WIDTH{1'b0}};
    q_o   = {WIDTH{1'b0}};
    if (is_div) begin
      // diff MSB clear means rem >= m: keep the difference, quotient bit 1.
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// FSM: IDLE -> PREP -> CALC (WIDTH or WIDTH/2 steps) -> FIX -> IDLE.
// Optional build macro MD_EARLY_OUT_EN: halves the iteration count when the
// multiplier / dividend magnitude fits in the lower half-word.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int HALF = WIDTH / 2;

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, qr_q, qr_d, m_q, m_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d, early_q, early_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_step, qr_step;
  logic [2*WIDTH-1:0] prod_raw, prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_i  (acc_q),
    .q_i    (qr_q),
    .m_i    (m_q),
    .acc_o  (acc_step),
    .q_o    (qr_step)
  );

  // Operand decode: signs and magnitudes of the latched operands.
  always_comb begin
    is_div = md_is_div(op_q);
    a_neg  = md_is_signed(op_q) & a_q[WIDTH-1];
    b_neg  = md_is_signed(op_q) & b_q[WIDTH-1];
    a_mag  = a_neg ? (-a_q) : a_q;
    b_mag  = b_neg ? (-b_q) : b_q;
  end

  // Result correction: realign an early-out product, then restore signs.
  always_comb begin
    prod_raw = {acc_q, qr_q};
    if (early_q) begin
      prod_raw = prod_raw >> HALF;
    end else begin
      prod_raw = {acc_q, qr_q};
    end
    prod_res = neg_lo_q ? (-prod_raw) : prod_raw;
    quo_res  = neg_lo_q ? (-qr_q) : qr_q;
    rem_res  = neg_hi_q ? (-acc_q) : acc_q;
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    early_d  = early_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // cancel in IDLE only blocks a simultaneous start.
        if (start && !cancel) begin
          op_d    = md_op_e'(op);
          a_d     = src_a;
          b_d     = src_b;
          state_d = ST_PREP;
        end else if (!start) begin
          if (mthi) begin
            hi_d = src_a;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = src_a;
          end else begin
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREP: begin
        acc_d   = {WIDTH{1'b0}};
        cnt_d   = CW'(WIDTH);
        early_d = 1'b0;
        if (is_div) begin
          qr_d     = a_mag;
          m_d      = b_mag;
          dz_d     = (b_q == {WIDTH{1'b0}});
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
        end else begin
          qr_d     = b_mag;
          m_d      = a_mag;
          dz_d     = 1'b0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = 1'b0;
        end
`ifdef MD_EARLY_OUT_EN
        if (is_div) begin
          // Leading zero dividend bits would only shift in zero quotient bits.
          if ((a_mag[WIDTH-1:HALF] == {(WIDTH-HALF){1'b0}}) &&
              (b_q != {WIDTH{1'b0}})) begin
            cnt_d = CW'(HALF);
            qr_d  = a_mag << HALF;
          end else begin
            cnt_d = CW'(WIDTH);
          end
        end else begin
          // Upper multiplier bits are zero; product is realigned in FIX.
          if (b_mag[WIDTH-1:HALF] == {(WIDTH-HALF){1'b0}}) begin
            cnt_d   = CW'(HALF);
            early_d = 1'b1;
          end else begin
            cnt_d = CW'(WIDTH);
          end
        end
`endif
        state_d = ST_CALC;
      end

      ST_CALC: begin
        acc_d = acc_step;
        qr_d  = qr_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        if (!is_div) begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the operation without touching HI/LO.
    if (cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end else begin
      done_d  = done_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MULT;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      qr_q     <= {WIDTH{1'b0}};
      m_q      <= {WIDTH{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      early_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      early_q  <= early_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32).
module tb_md_unit;

`ifdef MD_EARLY_OUT_EN
  localparam int LAT_SHORT = 18;
`else
  localparam int LAT_SHORT = 34;
`endif
  localparam int LAT_FULL = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Launch one op and wait (bounded) for done; returns edge count and busy-high samples.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    logic seen;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    run_op(2'b00, 32'hFFFFFFFD, 32'h5, lat, bc);
    checks++; if (lat !== LAT_SHORT) begin failures++; $display("FAIL mult_latency got=%0d exp=%0d", lat, LAT_SHORT); end
    checks++; if (bc !== LAT_SHORT) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bc, LAT_SHORT); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFFFFF1); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL multu_latency got=%0d exp=%0d", lat, LAT_FULL); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'hFFFFFFFE); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'h1); end
  endtask

  task automatic test_div_signed();
    int lat, bc;
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, lat, bc);
    checks++; if (lat !== LAT_SHORT) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat, LAT_SHORT); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
    run_op(2'b10, 32'h7, 32'hFFFFFFFE, lat, bc);
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdiv_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL div_negdiv_hi got=%h exp=%h", hi, 32'h1); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=%0d", lat, LAT_FULL); end
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=%h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=%h", hi, 32'h0); end
  endtask

  task automatic test_divu_zero();
    int lat, bc;
    run_op(2'b11, 32'h1234, 32'h0, lat, bc);
    checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL divz_latency got=%0d exp=%0d", lat, LAT_FULL); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
    checks++; if (hi !== 32'h00001234) begin failures++; $display("FAIL divz_hi got=%h exp=%h", hi, 32'h1234); end
    run_op(2'b11, 32'd100, 32'd7, lat, bc);
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); end
  endtask

  task automatic test_cancel();
    int dcount;
    src_a = 32'hA5A5A5A5; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; src_a = 32'h0F0F0F0F; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_write got=%h exp=%h", hi, 32'hA5A5A5A5); end
    checks++; if (lo !== 32'h0F0F0F0F) begin failures++; $display("FAIL mtlo_write got=%h exp=%h", lo, 32'h0F0F0F0F); end
    op = 2'b00; src_a = 32'h3; src_b = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    checks++; if (dcount !== 0) begin failures++; $display("FAIL cancel_done_pulses got=%0d exp=0", dcount); end
    checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL cancel_hi got=%h exp=%h", hi, 32'hA5A5A5A5); end
    checks++; if (lo !== 32'h0F0F0F0F) begin failures++; $display("FAIL cancel_lo got=%h exp=%h", lo, 32'h0F0F0F0F); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic seen;
    op = 2'b01; src_a = 32'h2; src_b = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    op = 2'b11; src_a = 32'hDEAD; src_b = 32'h1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL busy_mthi_ignored got=%h exp=%h", hi, 32'hA5A5A5A5); end
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    checks++; if (lat !== LAT_SHORT) begin failures++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, LAT_SHORT); end
    checks++; if (lo !== 32'h6) begin failures++; $display("FAIL busy_start_lo got=%h exp=%h", lo, 32'h6); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL busy_start_hi got=%h exp=%h", hi, 32'h0); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_no_relaunch got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    src_a = 32'h5A5A5A5A; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {32'h5A5A5A5A, 32'h5A5A5A5A}) begin failures++; $display("FAIL mthi_mtlo_both got=%h_%h exp=5a5a5a5a_5a5a5a5a", hi, lo); end
    op = 2'b01; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
  endtask

  task automatic test_early();
    int lat, bc;
    run_op(2'b01, 32'd100, 32'd7, lat, bc);
    checks++; if (lat !== LAT_SHORT) begin failures++; $display("FAIL early_latency got=%0d exp=%0d", lat, LAT_SHORT); end
    checks++; if (lo !== 32'd700) begin failures++; $display("FAIL early_lo got=%h exp=%h", lo, 32'd700); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL early_hi got=%h exp=%h", hi, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_divu_zero();
    test_cancel();
    test_busy_ignore();
    test_reset_mid();
    test_early();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
